// File: rtl/weight_load_sched_if.sv
// rtl/weight_load_sched_if.sv - handshake and memory bundle for weight_load_sched
//
// Ports (slave = scheduler side):
//   i_start, i_abort     control pulses into the scheduler
//   o_mem_rden/o_mem_addr/i_mem_data   byte-wide preload memory read port
//   o_tdata/o_t_valid/i_t_ready        weight byte stream to LSTM_TOP
//   o_busy/o_done/o_aborted/o_byte_cnt transfer status
interface weight_load_sched_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 15
);
  logic                  i_start;
  logic                  i_abort;
  logic                  o_mem_rden;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] i_mem_data;
  logic [DATA_WIDTH-1:0] o_tdata;
  logic                  o_t_valid;
  logic                  i_t_ready;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_aborted;
  logic [ADDR_WIDTH-1:0] o_byte_cnt;

  modport slave (
    input  i_start, i_abort, i_mem_data, i_t_ready,
    output o_mem_rden, o_mem_addr, o_tdata, o_t_valid,
           o_busy, o_done, o_aborted, o_byte_cnt
  );

  modport master (
    output i_start, i_abort, i_mem_data, i_t_ready,
    input  o_mem_rden, o_mem_addr, o_tdata, o_t_valid,
           o_busy, o_done, o_aborted, o_byte_cnt
  );
endinterface

// File: rtl/weight_load_sched.sv
// rtl/weight_load_sched.sv - paces the LSTM weight image from preload memory to LSTM_TOP
//
// Ports:
//   i_clk_sys  system clock
//   r_reset    synchronous active-high reset
//   bus        weight_load_sched_if.slave: start/abort, memory read port,
//              tdata/t_valid/t_ready stream, busy/done/aborted/byte_cnt status
module weight_load_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 18432,
  parameter int ADDR_WIDTH = 15,
  parameter int GAP        = 29,
  parameter int RD_LATENCY = 1
) (
  input  logic                i_clk_sys,
  input  logic                r_reset,
  weight_load_sched_if.slave  bus
);

  // One counter serves both the read-latency wait and the inter-byte gap.
  localparam int CNT_MAX = (RD_LATENCY > GAP) ? RD_LATENCY : GAP;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]      RL_LAST  = CNT_W'(RD_LATENCY);
  localparam logic [CNT_W-1:0]      GAP_LAST = (GAP > 0) ? CNT_W'(GAP - 1) : '0;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_PRESENT,
    S_GAP,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      wait_q;
  logic [ADDR_WIDTH-1:0] byte_cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  aborted_q;

  logic cnt_clr, cnt_inc, start_take, capture, accept, abort_take;
  logic rden, t_valid;
  logic last_byte;

  assign last_byte = (byte_cnt_q == LAST_IDX);

  always_ff @(posedge i_clk_sys) begin
    if (r_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    start_take = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    abort_take = 1'b0;
    rden       = 1'b0;
    t_valid    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Abort wins over a simultaneous start.
        if (bus.i_start && !bus.i_abort) begin
          start_take = 1'b1;
          cnt_clr    = 1'b0;
          cnt_clr    = 1'b1;
          state_d    = S_READ;
        end
      end
      S_READ: begin
        // rden only on the entry cycle; data lands RD_LATENCY cycles later.
        rden = (wait_q == '0);
        if (wait_q == RL_LAST) begin
          capture = 1'b1;
          cnt_clr = 1'b1;
          state_d = S_PRESENT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_PRESENT: begin
        t_valid = 1'b1;
        if (bus.i_t_ready) begin
          accept  = 1'b1;
          cnt_clr = 1'b1;
          if (last_byte) begin
            state_d = S_DONE;
          end else if (GAP == 0) begin
            state_d = S_READ;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (wait_q == GAP_LAST) begin
          cnt_clr = 1'b1;
          state_d = S_READ;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every busy state; a byte handshaken in the same cycle
    // still counts, but any read in flight is dropped.
    if (state_q != S_IDLE && bus.i_abort) begin
      abort_take = 1'b1;
      capture    = 1'b0;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (r_reset) begin
      wait_q     <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      tdata_q    <= '0;
      aborted_q  <= 1'b0;
    end else begin
      aborted_q <= abort_take;

      if (cnt_clr) begin
        wait_q <= '0;
      end else if (cnt_inc) begin
        wait_q <= wait_q + 1'b1;
      end

      if (start_take) begin
        byte_cnt_q <= '0;
        addr_q     <= '0;
      end

      if (capture) begin
        tdata_q <= bus.i_mem_data;
      end

      if (accept) begin
        byte_cnt_q <= byte_cnt_q + 1'b1;
        // Wrap after the last byte so the address never reaches LENGTH.
        addr_q     <= last_byte ? '0 : addr_q + 1'b1;
      end
    end
  end

  assign bus.o_mem_rden = rden;
  assign bus.o_mem_addr = addr_q;
  assign bus.o_tdata    = tdata_q;
  assign bus.o_t_valid  = t_valid;
  assign bus.o_busy     = (state_q != S_IDLE);
  assign bus.o_done     = (state_q == S_DONE);
  assign bus.o_aborted  = aborted_q;
  assign bus.o_byte_cnt = byte_cnt_q;

endmodule
